// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM sequencing controller.
package sram_ctrl_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_SETUP     = 3'd1,
        WR_PULSE     = 3'd2,
        WR_VALID     = 3'd3,
        WR_DISABLE   = 3'd4,
        READ_ACCESS  = 3'd5,
        READ_VALID   = 3'd6,
        READ_DISABLE = 3'd7
    } state_t;

    // Strobe patterns, bit order {ce_n, oe_n, we_n, lb_n, ub_n}
    localparam logic [4:0] STROBE_OFF     = 5'b11111;
    localparam logic [4:0] STROBE_WR      = 5'b01000;
    localparam logic [4:0] STROBE_WR_HOLD = 5'b01100;
    localparam logic [4:0] STROBE_RD      = 5'b00100;

    // Largest of four cycle counts, used to size the shared phase counter
    function automatic int cyc_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Sequencer for a 256K x 16 asynchronous SRAM: latches one read or write
// request, walks the strobes through fixed-length setup/access/recovery
// phases and reports busy/valid to the host. The dq bus is never driven here.
module sram_controller #(
    parameter int ADDR_W             = sram_ctrl_pkg::ADDR_W,
    parameter int DATA_W             = sram_ctrl_pkg::DATA_W,
    parameter int READ_ACCESS_CYCLES = 12,
    parameter int WR_SETUP_CYCLES    = 4,
    parameter int WR_PULSE_CYCLES    = 6,
    parameter int DISABLE_CYCLES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] address_inputs,
    inout  wire  [DATA_W-1:0] dq,
    output logic              read_valid,
    output logic              wr_valid,
    output logic              read_busy,
    output logic              wr_busy,
    output logic [ADDR_W-1:0] address_out,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              lb_n,
    output logic              ub_n
);
    import sram_ctrl_pkg::*;

    localparam int MAX_CYC = cyc_max4(READ_ACCESS_CYCLES, WR_SETUP_CYCLES,
                                      WR_PULSE_CYCLES, DISABLE_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(READ_ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(WR_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(WR_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIS_LAST    = CNT_W'(DISABLE_CYCLES - 1);

    // Registers carry power-on values so outputs are defined before any reset
    state_t            state_r      = IDLE;
    logic [CNT_W-1:0]  cnt_r        = {CNT_W{1'b0}};
    logic [4:0]        strobe_r     = STROBE_OFF;
    logic              rd_busy_r    = 1'b0;
    logic              rd_valid_r   = 1'b0;
    logic              wr_busy_r    = 1'b0;
    logic              wr_valid_r   = 1'b0;
    logic [ADDR_W-1:0] address_r    = {ADDR_W{1'b0}};

    state_t            state_next_s;
    logic [4:0]        strobe_next_s;
    logic              rd_busy_next_s;
    logic              rd_valid_next_s;
    logic              wr_busy_next_s;
    logic              wr_valid_next_s;

    // The SRAM (or the host) owns dq; this block only observes the bus
    assign dq = {DATA_W{1'bz}};

    assign {ce_n, oe_n, we_n, lb_n, ub_n} = strobe_r;
    assign read_busy   = rd_busy_r;
    assign read_valid  = rd_valid_r;
    assign wr_busy     = wr_busy_r;
    assign wr_valid    = wr_valid_r;
    assign address_out = address_r;

    // Next-state decision; enables are only looked at in IDLE and in the valid states
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_en) begin
                    state_next_s = WR_SETUP;
                end else if (read_en) begin
                    state_next_s = READ_ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WR_SETUP: begin
                if (cnt_r == SETUP_LAST) state_next_s = WR_PULSE;
                else                     state_next_s = WR_SETUP;
            end
            WR_PULSE: begin
                if (cnt_r == PULSE_LAST) state_next_s = WR_VALID;
                else                     state_next_s = WR_PULSE;
            end
            WR_VALID: begin
                if (wr_en) state_next_s = WR_VALID;
                else       state_next_s = WR_DISABLE;
            end
            WR_DISABLE: begin
                if (cnt_r == DIS_LAST) state_next_s = IDLE;
                else                   state_next_s = WR_DISABLE;
            end
            READ_ACCESS: begin
                if (cnt_r == RD_LAST) state_next_s = READ_VALID;
                else                  state_next_s = READ_ACCESS;
            end
            READ_VALID: begin
                if (read_en) state_next_s = READ_VALID;
                else         state_next_s = READ_DISABLE;
            end
            READ_DISABLE: begin
                if (cnt_r == DIS_LAST) state_next_s = IDLE;
                else                   state_next_s = READ_DISABLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output pattern for the state being entered, so every output leaves a flop
    always_comb begin
        strobe_next_s   = STROBE_OFF;
        rd_busy_next_s  = 1'b0;
        rd_valid_next_s = 1'b0;
        wr_busy_next_s  = 1'b0;
        wr_valid_next_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                strobe_next_s = STROBE_OFF;
            end
            WR_SETUP, WR_DISABLE: begin
                strobe_next_s  = STROBE_OFF;
                wr_busy_next_s = 1'b1;
            end
            WR_PULSE: begin
                strobe_next_s  = STROBE_WR;
                wr_busy_next_s = 1'b1;
            end
            WR_VALID: begin
                strobe_next_s   = STROBE_WR_HOLD;
                wr_busy_next_s  = 1'b1;
                wr_valid_next_s = 1'b1;
            end
            READ_ACCESS: begin
                strobe_next_s  = STROBE_RD;
                rd_busy_next_s = 1'b1;
            end
            READ_VALID: begin
                strobe_next_s   = STROBE_RD;
                rd_busy_next_s  = 1'b1;
                rd_valid_next_s = 1'b1;
            end
            READ_DISABLE: begin
                strobe_next_s  = STROBE_OFF;
                rd_busy_next_s = 1'b1;
            end
            default: begin
                strobe_next_s = STROBE_OFF;
            end
        endcase
    end

    // State, phase counter, address latch and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            strobe_r   <= STROBE_OFF;
            rd_busy_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            wr_busy_r  <= 1'b0;
            wr_valid_r <= 1'b0;
            address_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            strobe_r   <= strobe_next_s;
            rd_busy_r  <= rd_busy_next_s;
            rd_valid_r <= rd_valid_next_s;
            wr_busy_r  <= wr_busy_next_s;
            wr_valid_r <= wr_valid_next_s;
            // Counter restarts at every phase change and sticks at its ceiling
            if (state_next_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // Address is captured only when a request is accepted
            if ((state_r == IDLE) && (state_next_s != IDLE)) begin
                address_r <= address_inputs;
            end else begin
                address_r <= address_r;
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM on dq and
// queue-based scoreboards for write completion and read data.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [17:0] address_inputs = 18'h0;
    wire  [15:0] dq;
    logic        read_valid, wr_valid, read_busy, wr_busy;
    logic [17:0] address_out;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    logic        host_drv = 1'b0;
    logic [15:0] host_data = 16'h0;
    logic [15:0] sram_mem [0:(1<<18)-1];
    logic        sram_drv;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } rd_exp_t;

    logic [17:0] wr_q[$];
    rd_exp_t     rd_q[$];
    logic [15:0] exp_mem [int];

    sram_controller dut (
        .clk(clk), .rst(rst), .read_en(read_en), .wr_en(wr_en),
        .address_inputs(address_inputs), .dq(dq),
        .read_valid(read_valid), .wr_valid(wr_valid),
        .read_busy(read_busy), .wr_busy(wr_busy), .address_out(address_out),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .lb_n(lb_n), .ub_n(ub_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: drives dq on reads, captures dq on the rising edge of we_n
    assign sram_drv = !ce_n && !oe_n && we_n;
    assign dq = host_drv ? host_data : (sram_drv ? sram_mem[address_out] : 16'hzzzz);

    always @(posedge we_n) begin
        if (!ce_n) sram_mem[address_out] = dq;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {ce_n, oe_n, we_n, lb_n, ub_n};
    endfunction

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input bit with_rd);
        int edges;
        logic [17:0] exp_a;
        wr_en = 1'b1;
        read_en = with_rd;
        address_inputs = a;
        host_data = d;
        host_drv = 1'b1;
        wr_q.push_back(a);
        exp_mem[int'(a)] = d;
        tick(1);
        check_value("wr_e1_busy", {30'd0, read_busy, wr_busy}, 32'h1);
        check_value("wr_e1_valid", {31'd0, wr_valid}, 32'h0);
        check_value("wr_e1_strb", {27'd0, strobes()}, 32'h1F);
        tick(3);
        check_value("wr_e4_strb", {27'd0, strobes()}, 32'h1F);
        address_inputs = ~a;
        read_en = !read_en;
        tick(1);
        check_value("wr_e5_strb", {27'd0, strobes()}, 32'h08);
        check_value("wr_e5_dq", {16'd0, dq}, {16'd0, d});
        edges = 5;
        while (!wr_valid && edges < 40) begin
            tick(1);
            edges++;
        end
        check_value("wr_valid_edge", edges, 32'd11);
        exp_a = wr_q.pop_front();
        check_value("wr_addr", {14'd0, address_out}, {14'd0, exp_a});
        check_value("wr_hold_strb", {27'd0, strobes()}, 32'h0C);
        check_value("wr_no_rbusy", {31'd0, read_busy}, 32'h0);
        read_en = 1'b0;
        tick(1);
        check_value("wr_valid_held", {31'd0, wr_valid}, 32'h1);
        wr_en = 1'b0;
        host_drv = 1'b0;
        tick(1);
        check_value("wr_dis_strb", {27'd0, strobes()}, 32'h1F);
        check_value("wr_dis_flags", {30'd0, wr_busy, wr_valid}, 32'h2);
        tick(2);
        check_value("wr_idle_busy", {30'd0, read_busy, wr_busy}, 32'h0);
    endtask

    task automatic do_read(input logic [17:0] a);
        int edges;
        rd_exp_t e;
        rd_exp_t got;
        read_en = 1'b1;
        address_inputs = a;
        e.addr = a;
        e.data = exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : 16'h0;
        rd_q.push_back(e);
        tick(1);
        check_value("rd_e1_busy", {30'd0, read_busy, wr_busy}, 32'h2);
        check_value("rd_e1_strb", {27'd0, strobes()}, 32'h04);
        address_inputs = a ^ 18'h15555;
        wr_en = 1'b1;
        edges = 1;
        while (!read_valid && edges < 40) begin
            tick(1);
            edges++;
        end
        check_value("rd_valid_edge", edges, 32'd13);
        got = rd_q.pop_front();
        check_value("rd_addr", {14'd0, address_out}, {14'd0, got.addr});
        check_value("rd_data", {16'd0, dq}, {16'd0, got.data});
        wr_en = 1'b0;
        tick(2);
        check_value("rd_valid_held", {30'd0, read_busy, read_valid}, 32'h3);
        read_en = 1'b0;
        tick(1);
        check_value("rd_dis_flags", {30'd0, read_busy, read_valid}, 32'h2);
        check_value("rd_dis_strb", {27'd0, strobes()}, 32'h1F);
        tick(2);
        check_value("rd_idle_busy", {30'd0, read_busy, wr_busy}, 32'h0);
    endtask

    initial begin
        #1;
        check_value("pwr_busy", {30'd0, read_busy, wr_busy}, 32'h0);
        check_value("pwr_strb", {27'd0, strobes()}, 32'h1F);
        tick(1);
        check_value("idle_strb", {27'd0, strobes()}, 32'h1F);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_value("rst_addr", {14'd0, address_out}, 32'h0);

        do_write(18'h3FFFF, 16'h2004, 1'b0);
        do_read(18'h3FFFF);
        do_write(18'h00001, 16'hA5C3, 1'b1);
        do_read(18'h00001);
        do_write(18'h3FFFF, 16'h5A5A, 1'b0);
        do_read(18'h3FFFF);

        // Reset in the middle of the write pulse
        wr_en = 1'b1;
        address_inputs = 18'h000AA;
        host_data = 16'h1234;
        host_drv = 1'b1;
        tick(6);
        check_value("rstmid_pulse", {27'd0, strobes()}, 32'h08);
        rst = 1'b1;
        wr_en = 1'b0;
        host_drv = 1'b0;
        tick(1);
        rst = 1'b0;
        check_value("rstmid_strb", {27'd0, strobes()}, 32'h1F);
        check_value("rstmid_flags", {28'd0, read_busy, read_valid, wr_busy, wr_valid}, 32'h0);
        check_value("rstmid_state", {29'd0, dut.state_r}, {29'd0, sram_ctrl_pkg::IDLE});
        check_value("rstmid_addr", {14'd0, address_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
